// File: rtl/dec_scan_pkg.sv
// Shared constants and the active-low one-hot decode used by every channel.
package dec_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest decode the helper produces; callers cast down to 2**SEL_W bits.
  localparam int MAX_OUT = 64;

  // All ones except a single low bit at position sel.
  function automatic logic [MAX_OUT-1:0] dec_onehot_l(input int unsigned sel);
    return ~(64'd1 << sel);
  endfunction

endpackage

// File: rtl/dec_chan.sv
// One decoder channel: enable gate, direct/scan select mux and the Y_L register.
module dec_chan
  import dec_scan_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_l,
  input  logic                  i_g_l,
  input  logic                  i_scan,
  input  logic [SEL_W-1:0]      i_a,
  input  logic [SEL_W-1:0]      i_idx,
  output logic [2**SEL_W-1:0]   o_y_l
);

  localparam int NOUT = 2**SEL_W;

  logic [SEL_W-1:0] w_sel;
  logic [NOUT-1:0]  w_dec;
  logic [NOUT-1:0]  r_y_l;

  // Scan mode ignores A and decodes the shared next-state index instead.
  assign w_sel = i_scan ? i_idx : i_a;
  assign w_dec = NOUT'(dec_onehot_l(32'(w_sel)));

  // Disabled or reset channels park all outputs high.
  always_ff @(posedge i_clk) begin
    if (!i_reset_l)  r_y_l <= '1;
    else if (i_g_l)  r_y_l <= '1;
    else             r_y_l <= w_dec;
  end

  assign o_y_l = r_y_l;

endmodule

// File: rtl/dec_scan_n.sv
// Multi-channel active-low decoder with a shared prescaled scan index.
module dec_scan_n
  import dec_scan_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int NCH   = 2,
  parameter int DIV   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_l,
  input  logic                    i_mode,
  input  logic                    i_hold,
  input  logic [NCH-1:0]          i_g_l,
  input  logic [NCH*SEL_W-1:0]    i_a,
  output logic [NCH*(2**SEL_W)-1:0] o_y_l,
  output logic [SEL_W-1:0]        o_scan_idx,
  output logic                    o_frame
);

  localparam int          NOUT   = 2**SEL_W;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  logic             r_mode;
  logic [15:0]      r_presc;
  logic [SEL_W-1:0] r_idx;
  logic             r_frame;

  logic             w_mode_chg;
  logic             w_idle;
  logic             w_step;
  logic [SEL_W-1:0] w_idx_nxt;

  // A mode change or direct mode pins the scan state at zero for this edge.
  assign w_mode_chg = (i_mode != r_mode);
  assign w_idle     = w_mode_chg || (r_mode == MODE_DIRECT);
  assign w_step     = !w_idle && !i_hold && (r_presc == DIV_M1);
  assign w_idx_nxt  = w_idle ? '0 : (w_step ? r_idx + SEL_W'(1) : r_idx);

  // Shared scan state: mode register, prescaler, index and wrap pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset_l) begin
      r_mode  <= MODE_DIRECT;
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_mode  <= i_mode;
      r_idx   <= w_idx_nxt;
      r_frame <= w_step && (r_idx == '1);
      if (w_idle)                r_presc <= '0;
      else if (!i_hold)          r_presc <= (r_presc == DIV_M1) ? '0 : r_presc + 16'd1;
    end
  end

  // Channels decode the index they will show alongside, so Y_L and SCAN_IDX align.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    dec_chan #(.SEL_W(SEL_W)) u_chan (
      .i_clk     (i_clk),
      .i_reset_l (i_reset_l),
      .i_g_l     (i_g_l[g]),
      .i_scan    (i_mode),
      .i_a       (i_a[g*SEL_W +: SEL_W]),
      .i_idx     (w_idx_nxt),
      .o_y_l     (o_y_l[g*NOUT +: NOUT])
    );
  end

  assign o_scan_idx = r_idx;
  assign o_frame    = r_frame;

endmodule

// File: doc/dec_scan_n.md
DEC_SCAN_N -- requirements
Module: dec_scan_n

Interface
REQ-001 Parameter SEL_W, default 2, select width per channel; each channel drives 2^SEL_W outputs.
REQ-002 Parameter NCH, default 2, number of independent decoder channels.
REQ-003 Parameter DIV, default 4, scan-mode clock cycles per index step; legal range 1..65535.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RESET_L  input  1  synchronous, active-low reset.
REQ-006 MODE  input  1  0 = direct decode; 1 = scan.
REQ-007 HOLD  input  1  scan mode only; high freezes prescaler and scan index.
REQ-008 G_L  input  NCH  per-channel active-low enable.
REQ-009 A  input  NCH*SEL_W  per-channel select; channel i uses bits [i*SEL_W +: SEL_W].
REQ-010 Y_L  output  NCH*2^SEL_W  per-channel active-low one-hot outputs; channel i uses bits [i*2^SEL_W +: 2^SEL_W].
REQ-011 SCAN_IDX  output  SEL_W  current scan index.
REQ-012 FRAME  output  1  one-cycle pulse on scan-index wrap.

Function
REQ-013 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-014 Direct mode: Y_L of channel i shall go low on exactly bit A_i, all other bits high, one cycle after sampling A_i and G_L[i].
REQ-015 Any mode: G_L[i] high at an edge shall drive all 2^SEL_W bits of channel i high in the next cycle.
REQ-016 Scan mode: prescaler counts 0..DIV-1; at an edge with prescaler = DIV-1 and HOLD low, prescaler shall clear and SCAN_IDX shall increment modulo 2^SEL_W; otherwise prescaler +1.
REQ-017 Scan mode: A shall be ignored; every enabled channel's Y_L shall decode the SCAN_IDX value in the same cycle (Y_L computed from next-state index).
REQ-018 FRAME shall be high for exactly the one cycle following an edge at which SCAN_IDX stepped from 2^SEL_W-1 to 0; low at all other times.
REQ-019 HOLD high shall freeze prescaler and SCAN_IDX; Y_L shall still follow G_L per REQ-015; FRAME low.
REQ-020 Edge at which sampled MODE differs from registered mode: prescaler and SCAN_IDX shall clear to 0, FRAME stays low; new mode's decode applies from next cycle.
REQ-021 Direct mode: SCAN_IDX and prescaler held at 0; FRAME low.
REQ-022 DIV = 1: SCAN_IDX shall step every cycle while HOLD low.
REQ-023 SCAN_IDX shall have no illegal states (full power-of-two range).

Reset
REQ-024 RESET_L low at an edge shall set Y_L all ones, SCAN_IDX 0, prescaler 0, FRAME 0, registered mode 0 (direct), next cycle.
REQ-025 Reset shall override MODE, HOLD and G_L, including mid-scan and mid-hold.
REQ-026 First edge with RESET_L high shall behave as a normal edge from the reset state.

Structure
REQ-027 Package dec_scan_pkg holds MODE_DIRECT/MODE_SCAN constants and the active-low one-hot decode function.
REQ-028 Sub-module dec_chan (one registered channel: enable, select, mode-mux, Y_L register) instantiated NCH times via generate.
REQ-029 Prescaler, scan index, mode register and FRAME logic in the top level, shared by all channels.

Verification (SEL_W=2, NCH=2, DIV=4)
REQ-030 Direct: MODE=0, G_L=2'b00, A=4'b10_01 -> next cycle Y_L = 8'b1011_1101.
REQ-031 Enable: G_L=2'b10, same A -> Y_L = 8'b1111_1101; after reset Y_L = 8'hFF, SCAN_IDX=0, FRAME=0.
REQ-032 Scan: MODE=1, HOLD=0, G_L=0 for 20 cycles -> SCAN_IDX steps 0,1,2,3,0 every 4 cycles, both channels' Y_L equal decode of SCAN_IDX, FRAME high one cycle after the 3->0 step.
REQ-033 Hold: HOLD=1 for 10 cycles at SCAN_IDX=2 -> SCAN_IDX stays 2, Y_L per channel 4'b1011; resumes with remaining prescaler count after release.
REQ-034 Mode switch and reset mid-scan: MODE 1->0 at SCAN_IDX=3 -> SCAN_IDX=0, no FRAME; RESET_L low at SCAN_IDX=2 -> Y_L=8'hFF, SCAN_IDX=0, direct mode.
